// File: rtl/chaos_pkg.sv
// rtl/chaos_pkg.sv - shared types and constants for the logistic-map iteration controller
package chaos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SUB  = 3'd1,
        ST_MUL1 = 3'd2,
        ST_MUL2 = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } chaos_state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    localparam logic [31:0] FP_ONE = 32'h3F800000;

endpackage

// File: rtl/fpu_select.sv
// rtl/fpu_select.sv - selects the add, sub or mul unit result onto the shared FPU result bus
module fpu_select
    import chaos_pkg::*;
(
    input  logic [1:0]  op_sel,
    input  logic [31:0] add_result,
    input  logic [31:0] sub_result,
    input  logic [31:0] mul_result,
    output logic [31:0] fpu_result
);

    always_comb begin
        fpu_result = 32'h0;
        case (op_sel)
            OP_ADD:  fpu_result = add_result;
            OP_SUB:  fpu_result = sub_result;
            OP_MUL:  fpu_result = mul_result;
            default: fpu_result = 32'h0;
        endcase
    end

endmodule

// File: rtl/chaos_iter_ctrl.sv
// rtl/chaos_iter_ctrl.sv - sequences x(n+1) = r*x(n)*(1-x(n)) over a shared external FPU
module chaos_iter_ctrl
    import chaos_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [31:0]      r_param,
    input  logic [CNT_W-1:0] n_iter,
    output logic [1:0]       op_sel,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    input  logic [31:0]      fpu_result,
    output logic [31:0]      x_out,
    output logic             x_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    chaos_state_t     state_q, state_d;
    logic [31:0]      x_q, r_q, t1_q, t2_q, x_out_q;
    logic [CNT_W-1:0] cnt_q;

    // The FPU is combinational, so each state captures the result of the op it drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= 32'h0;
            r_q     <= 32'h0;
            t1_q    <= 32'h0;
            t2_q    <= 32'h0;
            x_out_q <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q   <= seed;
                        r_q   <= r_param;
                        cnt_q <= n_iter;
                    end
                end
                ST_SUB:  t1_q <= fpu_result;
                ST_MUL1: t2_q <= fpu_result;
                ST_MUL2: begin
                    x_q     <= fpu_result;
                    x_out_q <= fpu_result;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        op_sel  = OP_IDLE;
        op_a    = 32'h0;
        op_b    = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n_iter == '0) ? ST_DONE : ST_SUB;
                end
            end
            ST_SUB: begin
                op_sel  = OP_SUB;
                op_a    = FP_ONE;
                op_b    = x_q;
                state_d = ST_MUL1;
            end
            ST_MUL1: begin
                op_sel  = OP_MUL;
                op_a    = r_q;
                op_b    = x_q;
                state_d = ST_MUL2;
            end
            ST_MUL2: begin
                op_sel  = OP_MUL;
                op_a    = t1_q;
                op_b    = t2_q;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                // cnt_q already reflects this iterate's decrement.
                if (out_ready) begin
                    state_d = (cnt_q == '0) ? ST_DONE : ST_SUB;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign x_out   = x_out_q;
    assign x_valid = (state_q == ST_OUT);
    assign done    = (state_q == ST_DONE);
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_chaos_iter_ctrl.sv
// tb/tb_chaos_iter_ctrl.sv - scoreboard bench for chaos_iter_ctrl with a real-valued FPU model
module tb_chaos_iter_ctrl;

    localparam int TB_CNT_W = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [31:0]         seed = 32'h0;
    logic [31:0]         r_param = 32'h0;
    logic [TB_CNT_W-1:0] n_iter = '0;
    logic [1:0]          op_sel;
    logic [31:0]         op_a, op_b, fpu_result, x_out;
    logic                x_valid, busy, done;
    logic                out_ready = 1'b1;
    logic [31:0]         add_res, sub_res, mul_res;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int accepts = 0;
    int last_acc_cyc = -100;
    logic [31:0] exp_q[$];

    chaos_iter_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .r_param(r_param),
        .n_iter(n_iter), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
        .fpu_result(fpu_result), .x_out(x_out), .x_valid(x_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    fpu_select u_fpu_sel (
        .op_sel(op_sel), .add_result(add_res), .sub_result(sub_res),
        .mul_result(mul_res), .fpu_result(fpu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        logic [10:0] e;
        if (f[30:23] == 8'h0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        b = {f[31], e, f[22:0], 29'h0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e11;
        int e;
        b = $realtobits(r);
        e11 = b[62:52];
        e = int'(e11) - 896;
        if (b[62:0] == 63'h0 || e <= 0) return 32'h0;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    always_comb begin
        add_res = r2f(f2r(op_a) + f2r(op_b));
        sub_res = r2f(f2r(op_a) - f2r(op_b));
        mul_res = r2f(f2r(op_a) * f2r(op_b));
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Scoreboard monitor: every accepted iterate is matched against the queued expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (x_valid && out_ready) begin
                accepts++;
                last_acc_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_iterate: got %h, expected none", x_out);
                end else begin
                    e = exp_q.pop_front();
                    if (x_out !== e) begin
                        miscompares++;
                        $display("FAIL iterate: got %h, expected %h", x_out, e);
                    end
                end
            end
        end
    end

    task automatic run_start(input logic [31:0] s, input logic [31:0] r,
                             input logic [TB_CNT_W-1:0] n);
        seed = s;
        r_param = r;
        n_iter = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no done, expected done within 200 cycles", name);
        end
    endtask

    task automatic wait_xvalid(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (x_valid) begin
                seen = 1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int dc;
        int acc0;
        int saw;

        @(negedge clk);
        chk("rst_x_valid", {31'h0, x_valid}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_op_sel", {30'h0, op_sel}, 32'h3);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_op_b", op_b, 32'h0);
        chk("rst_x_out", x_out, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // x0=0.25, r=2: 0.375 then 0.46875; FPU bus probed for iteration 1
        exp_q.push_back(32'h3EC00000);
        exp_q.push_back(32'h3EF00000);
        @(posedge clk);
        #1 run_start(32'h3E800000, 32'h40000000, 3'd2);
        @(negedge clk);
        chk("sub_op_sel", {30'h0, op_sel}, 32'h1);
        chk("sub_op_a", op_a, 32'h3F800000);
        chk("sub_op_b", op_b, 32'h3E800000);
        @(negedge clk);
        chk("mul1_op_sel", {30'h0, op_sel}, 32'h2);
        chk("mul1_op_a", op_a, 32'h40000000);
        chk("mul1_op_b", op_b, 32'h3E800000);
        @(negedge clk);
        chk("mul2_op_sel", {30'h0, op_sel}, 32'h2);
        chk("mul2_op_a", op_a, 32'h3F400000);
        chk("mul2_op_b", op_b, 32'h3F000000);
        @(negedge clk);
        chk("latency_x_valid", {31'h0, x_valid}, 32'h1);
        chk("out_op_sel", {30'h0, op_sel}, 32'h3);
        wait_done("run_a_done", dc);
        chk("run_a_done_after_accept", 32'(dc), 32'(last_acc_cyc + 1));
        @(negedge clk);
        chk("run_a_done_one_cycle", {31'h0, done}, 32'h0);
        chk("run_a_idle", {31'h0, busy}, 32'h0);

        // n_iter=0: straight to DONE, no iterate
        @(posedge clk);
        #1 acc0 = accepts;
        run_start(32'h3E800000, 32'h40000000, 3'd0);
        @(negedge clk);
        chk("zero_done", {31'h0, done}, 32'h1);
        chk("zero_no_valid", {31'h0, x_valid}, 32'h0);
        chk("zero_op_sel", {30'h0, op_sel}, 32'h3);
        @(negedge clk);
        chk("zero_done_drop", {31'h0, done}, 32'h0);
        chk("zero_idle", {31'h0, busy}, 32'h0);
        chk("zero_no_accept", 32'(accepts - acc0), 32'h0);

        // back-pressure: x_out held for 5 cycles with no FPU op
        out_ready = 1'b0;
        exp_q.push_back(32'h3EC00000);
        @(posedge clk);
        #1 run_start(32'h3E800000, 32'h40000000, 3'd1);
        wait_xvalid("bp_reach_out");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_x_valid", {31'h0, x_valid}, 32'h1);
            chk("bp_x_out", x_out, 32'h3EC00000);
            chk("bp_op_sel", {30'h0, op_sel}, 32'h3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("bp_done", dc);

        // start re-pulsed during MUL1 with different operands is ignored
        exp_q.push_back(32'h3EC00000);
        exp_q.push_back(32'h3EF00000);
        @(posedge clk);
        #1 acc0 = accepts;
        run_start(32'h3E800000, 32'h40000000, 3'd2);
        @(posedge clk);
        #1 run_start(32'h3F000000, 32'h40400000, 3'd5);
        wait_done("restart_done", dc);
        chk("restart_accepts", 32'(accepts - acc0), 32'd2);

        // reset during MUL2 abandons the run with no done
        @(posedge clk);
        #1 run_start(32'h3E800000, 32'h40000000, 3'd2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_x_valid", {31'h0, x_valid}, 32'h0);
        chk("midrst_op_sel", {30'h0, op_sel}, 32'h3);
        chk("midrst_op_a", op_a, 32'h0);
        chk("midrst_x_out", x_out, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk("midrst_no_done", 32'(saw), 32'h0);
        exp_q.push_back(32'h3EC00000);
        @(posedge clk);
        #1 run_start(32'h3E800000, 32'h40000000, 3'd1);
        wait_done("post_rst_done", dc);

        // zero seed: FPU returns 0 and it passes straight through
        exp_q.push_back(32'h00000000);
        @(posedge clk);
        #1 run_start(32'h00000000, 32'h40000000, 3'd1);
        wait_done("zero_seed_done", dc);

        // maximum count 2^3-1: x=0.5 is a fixed point of r=2, seven iterates
        for (int i = 0; i < 7; i++) exp_q.push_back(32'h3F000000);
        @(posedge clk);
        #1 acc0 = accepts;
        run_start(32'h3F000000, 32'h40000000, 3'd7);
        wait_done("max_done", dc);
        chk("max_accepts", 32'(accepts - acc0), 32'd7);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
